// File: rtl/tile_fetch_seq.sv
// tile_fetch_seq: per-group Fix/A/B tilemap fetch, GFX ROM addressing and fine-scroll outputs; define TILE_FLIP_Y_EN to enable attr[1] vertical flip
module tile_fetch_seq (
    input  logic        clk_24M,
    input  logic        nRES,
    input  logic        CE6,
    input  logic [8:0]  PXH,
    input  logic [7:0]  ROW,
    input  logic        REG_WR,
    input  logic [2:0]  REG_A,
    input  logic [7:0]  REG_D,
    output logic [12:0] VA,
    input  logic [15:0] VD,
    output logic [12:0] GA,
    output logic [7:0]  COL,
    output logic [2:0]  ZA,
    output logic [2:0]  ZB
);
    logic [8:0]  sxa, sxb;
    logic [7:0]  sya, syb;
    logic [2:0]  ctrl;
    logic [5:0]  sh_xa, sh_xb;
    logic [7:0]  sh_ya, sh_yb;
    logic [2:0]  sh_ctrl;
    logic [2:0]  yl, yl_n;
    logic [2:0]  s;
    logic [5:0]  tca, tcb;
    logic [7:0]  ya, yb;
    logic [12:0] va_n, ga_n;
    logic        fetch, cap, en, flip;

`ifdef TILE_FLIP_Y_EN
    assign flip = VD[9];
`else
    assign flip = 1'b0;
`endif

    // fetch address and capture decode; fine X never carries into the tile column since the group base is 8-aligned
    always_comb begin
        s     = PXH[2:0];
        tca   = PXH[8:3] + 6'd1 + sh_xa;
        tcb   = PXH[8:3] + 6'd1 + sh_xb;
        ya    = ROW + sh_ya;
        yb    = ROW + sh_yb;
        va_n  = s == 3'd4 ? {2'b01, ya[7:3], tca} : s == 3'd6 ? {2'b10, yb[7:3], tcb} : {2'b00, ROW[7:3], PXH[8:3] + 6'd1};
        yl_n  = s == 3'd4 ? ya[2:0] : s == 3'd6 ? yb[2:0] : ROW[2:0];
        fetch = !s[0] && s != 3'd2;
        cap   = s[0] && s != 3'd3;
        en    = s == 3'd1 ? sh_ctrl[0] : s == 3'd5 ? sh_ctrl[1] : sh_ctrl[2];
        ga_n  = {VD[11:10], VD[7:0], yl ^ {3{flip}}};
    end

    // live scroll/control registers, written on any clock
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            sxa  <= '0;
            sxb  <= '0;
            sya  <= '0;
            syb  <= '0;
            ctrl <= 3'b111;
        end else if (REG_WR) begin
            case (REG_A)
                3'd0: sxa[7:0] <= REG_D;
                3'd1: sxa[8]   <= REG_D[0];
                3'd2: sya      <= REG_D;
                3'd3: sxb[7:0] <= REG_D;
                3'd4: sxb[8]   <= REG_D[0];
                3'd5: syb      <= REG_D;
                3'd6: ctrl     <= REG_D[2:0];
                default: ;
            endcase
        end
    end

    // group-start shadow copy, VRAM address issue and VD capture into GA/COL
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            sh_xa   <= '0;
            sh_xb   <= '0;
            sh_ya   <= '0;
            sh_yb   <= '0;
            sh_ctrl <= '0;
            ZA      <= '0;
            ZB      <= '0;
            VA      <= '0;
            yl      <= '0;
            GA      <= '0;
            COL     <= '0;
        end else if (CE6) begin
            if (s == 3'd0) begin
                sh_xa   <= sxa[8:3];
                sh_xb   <= sxb[8:3];
                sh_ya   <= sya;
                sh_yb   <= syb;
                sh_ctrl <= ctrl;
                ZA      <= sxa[2:0];
                ZB      <= sxb[2:0];
            end
            if (fetch) begin
                VA <= va_n;
                yl <= yl_n;
            end
            if (cap) begin
                GA  <= en ? ga_n : '0;
                COL <= en ? VD[15:8] : '0;
            end
        end
    end
endmodule

// File: tb/tb_tile_fetch_seq.sv
// tb_tile_fetch_seq: directed checks of fetch addressing, scroll shadowing, layer enables and reset
module tb_tile_fetch_seq;
    logic        clk_24M = 1'b0;
    logic        nRES = 1'b1;
    logic        CE6 = 1'b0;
    logic [8:0]  PXH = '0;
    logic [7:0]  ROW = '0;
    logic        REG_WR = 1'b0;
    logic [2:0]  REG_A = '0;
    logic [7:0]  REG_D = '0;
    logic [12:0] VA;
    logic [15:0] VD = '0;
    logic [12:0] GA;
    logic [7:0]  COL;
    logic [2:0]  ZA;
    logic [2:0]  ZB;
    int          errors = 0;
    int          checks = 0;

`ifdef TILE_FLIP_Y_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    tile_fetch_seq dut (
        .clk_24M(clk_24M), .nRES(nRES), .CE6(CE6), .PXH(PXH), .ROW(ROW),
        .REG_WR(REG_WR), .REG_A(REG_A), .REG_D(REG_D), .VA(VA), .VD(VD),
        .GA(GA), .COL(COL), .ZA(ZA), .ZB(ZB)
    );

    always #20 clk_24M = ~clk_24M;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pix(input logic [8:0] p, input logic [15:0] d);
        PXH = p;
        VD  = d;
        CE6 = 1'b1;
        @(posedge clk_24M);
        #1;
        CE6 = 1'b0;
        @(posedge clk_24M);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        REG_WR = 1'b1;
        REG_A  = a;
        REG_D  = d;
        @(posedge clk_24M);
        #1;
        REG_WR = 1'b0;
    endtask

    initial begin
        #3 nRES = 1'b0;
        #2;
        chk("rst_va", 16'(VA), 16'h0);
        chk("rst_ga", 16'(GA), 16'h0);
        chk("rst_col", 16'(COL), 16'h0);
        chk("rst_za", 16'(ZA), 16'h0);
        chk("rst_zb", 16'(ZB), 16'h0);
        @(posedge clk_24M);
        #1 nRES = 1'b1;
        @(posedge clk_24M);
        #1;
        // Fix fetch at group 0x020, row 0x10
        ROW = 8'h10;
        pix(9'h020, 16'h0);
        chk("fix_va", 16'(VA), 16'h0085);
        pix(9'h021, 16'h5A3C);
        chk("fix_ga", 16'(GA), FLIP ? 16'h11E7 : 16'h11E0);
        chk("fix_col", 16'(COL), 16'h005A);
        pix(9'h022, 16'h0);
        chk("fix_ga_hold", 16'(GA), FLIP ? 16'h11E7 : 16'h11E0);
        // A layer wrap: SXA=0x1FC, SYA=0xFE at group 0x1F8, row 5
        wr(3'd0, 8'hFC);
        wr(3'd1, 8'h01);
        wr(3'd2, 8'hFE);
        ROW = 8'h05;
        pix(9'h1F8, 16'h0);
        chk("wrap_za", 16'(ZA), 16'h4);
        pix(9'h1F9, 16'h0);
        pix(9'h1FA, 16'h0);
        pix(9'h1FB, 16'h0);
        pix(9'h1FC, 16'h0);
        chk("wrap_va_a", 16'(VA), 16'h083F);
        pix(9'h1FD, 16'h0212);
        chk("flip_ga", 16'(GA), FLIP ? 16'h0094 : 16'h0093);
        chk("flip_col", 16'(COL), 16'h0002);
        pix(9'h1FE, 16'h0);
        chk("wrap_va_b", 16'(VA), 16'h1000);
        pix(9'h1FF, 16'h0);
        // mid-group scroll write applies from next group only
        wr(3'd0, 8'h00);
        wr(3'd1, 8'h00);
        wr(3'd2, 8'h00);
        ROW = 8'h10;
        pix(9'h040, 16'h0);
        pix(9'h041, 16'h0);
        pix(9'h042, 16'h0);
        pix(9'h043, 16'h0);
        wr(3'd0, 8'h10);
        pix(9'h044, 16'h0);
        chk("late_wr_va", 16'(VA), 16'h0889);
        chk("late_wr_za", 16'(ZA), 16'h0);
        for (int p = 'h45; p < 'h4C; p++) pix(9'(p), 16'h0);
        pix(9'h04C, 16'h0);
        chk("next_grp_va", 16'(VA), 16'h088C);
        // write coincident with shadow copy: shadow keeps pre-write value
        for (int p = 'h4D; p < 'h50; p++) pix(9'(p), 16'h0);
        REG_WR = 1'b1;
        REG_A  = 3'd0;
        REG_D  = 8'h13;
        PXH    = 9'h050;
        CE6    = 1'b1;
        @(posedge clk_24M);
        #1;
        REG_WR = 1'b0;
        CE6    = 1'b0;
        chk("coinc_za", 16'(ZA), 16'h0);
        for (int p = 'h51; p < 'h54; p++) pix(9'(p), 16'h0);
        pix(9'h054, 16'h0);
        chk("coinc_va", 16'(VA), 16'h088D);
        for (int p = 'h55; p < 'h58; p++) pix(9'(p), 16'h0);
        pix(9'h058, 16'h0);
        chk("coinc_za_next", 16'(ZA), 16'h3);
        for (int p = 'h59; p < 'h60; p++) pix(9'(p), 16'h0);
        // layer enables CTRL=101
        wr(3'd6, 8'h05);
        ROW = 8'h07;
        pix(9'h060, 16'h0);
        pix(9'h061, 16'hFFFF);
        chk("en_fix_ga", 16'(GA), FLIP ? 16'h1FF8 : 16'h1FFF);
        chk("en_fix_col", 16'(COL), 16'h00FF);
        for (int p = 'h62; p < 'h65; p++) pix(9'(p), 16'h0);
        pix(9'h065, 16'hFFFF);
        chk("dis_a_ga", 16'(GA), 16'h0);
        chk("dis_a_col", 16'(COL), 16'h0);
        pix(9'h066, 16'h0);
        pix(9'h067, 16'hFFFF);
        chk("en_b_ga", 16'(GA), FLIP ? 16'h1FF8 : 16'h1FFF);
        chk("en_b_col", 16'(COL), 16'h00FF);
        // mid-group async reset
        pix(9'h068, 16'h0);
        pix(9'h069, 16'hFFFF);
        nRES = 1'b0;
        #2;
        chk("mid_rst_va", 16'(VA), 16'h0);
        chk("mid_rst_ga", 16'(GA), 16'h0);
        chk("mid_rst_col", 16'(COL), 16'h0);
        chk("mid_rst_za", 16'(ZA), 16'h0);
        @(posedge clk_24M);
        #1 nRES = 1'b1;
        // all layers enabled again after reset
        for (int p = 'h70; p < 'h75; p++) pix(9'(p), 16'h0);
        pix(9'h075, 16'h0301);
        chk("rst_ctrl_a_col", 16'(COL), 16'h0003);
        pix(9'h076, 16'h0);
        pix(9'h077, 16'h0401);
        chk("rst_ctrl_b_col", 16'(COL), 16'h0004);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
